// File: rtl/pipeline_control_pkg.sv
// Shared CPU pipeline definitions: stage indices, enable levels and default depth.
package pipeline_control_pkg;

  localparam int unsigned STAGE_PC  = 0;
  localparam int unsigned STAGE_IF  = 1;
  localparam int unsigned STAGE_ID  = 2;
  localparam int unsigned STAGE_EX  = 3;
  localparam int unsigned STAGE_MEM = 4;
  localparam int unsigned STAGE_WB  = 5;

  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;

  localparam int unsigned DEFAULT_NUM_STAGES = 6;

endpackage

// File: rtl/pipeline_control_stall_mask.sv
// Thermometer fill: every bit at or below the highest set request bit is driven high.
module pipeline_control_stall_mask #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] mask
);

  logic acc;

  always_comb begin
    acc  = 1'b0;
    mask = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc     = acc | request[i];
      mask[i] = acc;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline freeze controller: stall thermometer, multi-cycle hold, registered flush/redirect
// and a saturating stall-cycle counter.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEFAULT_NUM_STAGES,
  parameter int unsigned HOLD_STAGE  = STAGE_EX,
  parameter int unsigned HOLD_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_STAGES-1:0]  stall_request,
  input  logic                   hold_start,
  input  logic [HOLD_WIDTH-1:0]  hold_cycles,
  input  logic                   flush_request,
  input  logic [ADDR_WIDTH-1:0]  flush_pc,
  output logic [NUM_STAGES-1:0]  stall,
  output logic                   hold_busy,
  output logic                   flush,
  output logic [ADDR_WIDTH-1:0]  new_pc,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic                   flush_q, flush_d;
  logic [ADDR_WIDTH-1:0]  new_pc_q, new_pc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                  hold_start_valid;
  logic                  hold_src;
  logic [NUM_STAGES-1:0] sources;
  logic [NUM_STAGES-1:0] mask;

  assign hold_busy        = (hold_q != '0);
  assign hold_start_valid = hold_start && (hold_cycles != '0);
  // The start cycle already stalls, so the counter only covers the remaining N-1 cycles.
  assign hold_src         = hold_busy || hold_start_valid;

  always_comb begin
    sources             = stall_request;
    sources[HOLD_STAGE] = stall_request[HOLD_STAGE] | hold_src;
  end

  pipeline_control_stall_mask #(
    .WIDTH (NUM_STAGES)
  ) u_stall_mask (
    .request (sources),
    .mask    (mask)
  );

  // Flushed stages must advance so bubbles can enter them.
  assign stall = ((reset == RESET_ENABLE) || flush_q) ? '0 : mask;

  always_comb begin
    hold_d   = hold_q;
    flush_d  = flush_request;
    new_pc_d = new_pc_q;
    count_d  = count_q;

    if (flush_request) begin
      hold_d   = '0;
      new_pc_d = flush_pc;
    end else if (hold_busy) begin
      hold_d = hold_q - HOLD_WIDTH'(1);
    end else if (hold_start_valid && !flush_q) begin
      hold_d = hold_cycles - HOLD_WIDTH'(1);
    end

    if (stall[STAGE_PC] && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      hold_q   <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      count_q  <= '0;
    end else begin
      hold_q   <= hold_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      count_q  <= count_d;
    end
  end

  assign flush       = flush_q;
  assign new_pc      = new_pc_q;
  assign stall_count = count_q;

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Parametrised successor to the CPU's stall controller.
- Sits beside the pipeline registers and produces the per-stage freeze vector from per-stage stall requests.
- Adds a multi-cycle hold counter, so a multi-cycle unit such as mul/div can request N stall cycles with one pulse.
- Adds a registered pipeline flush with redirect PC, and a saturating stall-cycle performance counter.

Parameters:
- NUM_STAGES, 6: stage count. Index 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- HOLD_STAGE, 3: stage index that owns the hold counter (ex).
- HOLD_WIDTH, 6: width of hold_cycles and of the internal counter.
- ADDR_WIDTH, 32: width of the redirect PC.
- COUNT_WIDTH, 32: width of the stall performance counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_request  in  NUM_STAGES  bit i = stage i requests a stall this cycle (combinational from that stage).
- hold_start  in  1  one-cycle pulse that starts a multi-cycle hold.
- hold_cycles  in  HOLD_WIDTH  total stall cycles for the hold; sampled with hold_start.
- flush_request  in  1  exception/redirect request.
- flush_pc  in  ADDR_WIDTH  redirect target; sampled with flush_request.
- stall  out  NUM_STAGES  bit i = 1 freezes stage i's input register.
- hold_busy  out  1  hold counter is nonzero.
- flush  out  1  registered one-cycle flush pulse.
- new_pc  out  ADDR_WIDTH  registered redirect target; valid when flush = 1.
- stall_count  out  COUNT_WIDTH  number of cycles with stall[0] = 1, saturating.

Behaviour:
- Reset:
  - The single clock is clock; reset is synchronous and active-high.
  - Reset clears the hold counter, flush, new_pc and stall_count to 0.
  - stall = 0 while reset = 1, regardless of other inputs.
- Stall source set (combinational):
  - stall_request[i] for every i.
  - Plus stage HOLD_STAGE when hold_busy = 1, or when hold_start = 1 with hold_cycles != 0.
- Stall vector:
  - Let k be the highest active source index. Then stall[k:0] = all ones and stall[NUM_STAGES-1:k+1] = 0.
  - No active source gives stall = 0.
  - Example, NUM_STAGES = 6: ex request gives 001111; id request gives 000111; a wb request gives 111111.
- Flush override:
  - While flush = 1, stall = 0 and stall_request is ignored.
  - The flushed stages must advance so that bubbles enter them.
- Hold counter:
  - hold_start with N = hold_cycles, while the counter is 0 and flush = 0: stall from HOLD_STAGE is asserted in the start cycle and the counter loads N-1. Stall is therefore asserted for exactly N consecutive cycles.
  - N = 0: no effect.
  - N = 1: single-cycle stall, counter stays 0.
  - The counter decrements each cycle while nonzero.
  - hold_start while hold_busy = 1: ignored (no reload, no extend).
- Flush:
  - flush_request in cycle t gives flush = 1 and new_pc = flush_pc in cycle t+1, for one cycle only.
  - A flush_request in the flush = 1 cycle produces another pulse in the next cycle with the new flush_pc.
  - flush_request clears the hold counter at the same edge; the hold is abandoned.
  - A simultaneous hold_start is dropped.
  - flush_request has no effect on stall in cycle t.
- Performance counter:
  - stall_count increments at each edge where stall[0] = 1 and reset = 0.
  - It holds at all-ones; no wrap.
- Reset mid-operation: reset during an active hold or a flush pulse clears all state at that edge; stall = 0 during reset.
- Latency: stall is zero-cycle combinational; flush and new_pc have one cycle of latency.

Decomposition:
- Shared package (cpu defines):
  - Stage index constants: STAGE_PC … STAGE_WB.
  - RESET_ENABLE and STALL_ENABLE.
  - Default NUM_STAGES.
- Sub-module stall_mask: pure combinational request vector → thermometer mask (highest-set-bit fill down to bit 0).
  - Reused by pipeline_control.
  - Unit-tested separately.

Test Plan:
- Reset asserted with stall_request = 6'b111111 → stall = 0, flush = 0, stall_count = 0; after deassert, stall = 6'b111111.
- stall_request = 6'b000100 (id) → stall = 6'b000111; stall_request = 6'b001100 (ex+id) → stall = 6'b001111; 6'b000000 → 0.
- hold_start with hold_cycles = 4 → stall = 6'b001111 for exactly 4 cycles, hold_busy high for 3; a second hold_start in cycle 2 is ignored; stall_count = 4.
- hold_cycles = 0 → no stall. hold_cycles = 1 → one stall cycle, hold_busy never high.
- Hold active (hold_cycles = 10), flush_request with flush_pc = 32'hBFC00380 in cycle 3 → next cycle flush = 1, new_pc = 32'hBFC00380, stall = 0, hold_busy = 0; flush low the cycle after.
- Force 2^COUNT_WIDTH-1 stall cycles with reduced COUNT_WIDTH = 4 → stall_count saturates at 4'hF.
